hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and memory-wait freezes.
// Optional stall-cycle counter port stall_cnt is built when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_RsAddr,
    input  logic [4:0]  id_RtAddr,
    input  logic        id_ex_MemRead,
    input  logic [4:0]  id_ex_RtAddr,
    input  logic        ex_BranchTaken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXWrite,
    output logic        EXMEMWrite,
    output logic        IDEXBubble,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        mem_timeout
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
    localparam logic [15:0] WaitMax    = 16'hFFFF;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        load_use;
    logic        mem_stall;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = id_ex_MemRead && (id_ex_RtAddr != 5'd0) &&
                      ((id_ex_RtAddr == id_RsAddr) || (id_ex_RtAddr == id_RtAddr));

    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        PCWrite       = 1'b0;
        IFIDWrite     = 1'b0;
        IDEXWrite     = 1'b0;
        EXMEMWrite    = 1'b0;
        IDEXBubble    = 1'b0;
        IFIDFlush     = 1'b0;
        IDEXFlush     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d    = StMemWait;
                    wait_cnt_d = '0;
                end else if (ex_BranchTaken) begin
                    PCWrite    = 1'b1;
                    IFIDWrite  = 1'b1;
                    IDEXWrite  = 1'b1;
                    EXMEMWrite = 1'b1;
                    IFIDFlush  = 1'b1;
                    IDEXFlush  = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID; ID/EX captures the NOP while EX drains.
                    IDEXWrite  = 1'b1;
                    EXMEMWrite = 1'b1;
                    IDEXBubble = 1'b1;
                end else begin
                    PCWrite    = 1'b1;
                    IFIDWrite  = 1'b1;
                    IDEXWrite  = 1'b1;
                    EXMEMWrite = 1'b1;
                end
            end

            StMemWait: begin
                if (mem_ready) begin
                    PCWrite    = 1'b1;
                    IFIDWrite  = 1'b1;
                    IDEXWrite  = 1'b1;
                    EXMEMWrite = 1'b1;
                    state_d    = StRun;
                end else begin
                    if (wait_cnt_q != WaitMax) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                    if (wait_cnt_d >= TimeoutVal) begin
                        mem_timeout_d = 1'b1;
                    end
                end
            end

            default: state_d = StRun;
        endcase

        // Reset forces every control output low without waiting for a clock edge.
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            IDEXBubble = 1'b0;
            IFIDFlush  = 1'b0;
            IDEXFlush  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!PCWrite) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT=4); stall_cnt checks need
// HAZARD_STALL_CNT_EN.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_RsAddr;
    logic [4:0] id_RtAddr;
    logic       id_ex_MemRead;
    logic [4:0] id_ex_RtAddr;
    logic       ex_BranchTaken;
    logic       mem_req;
    logic       mem_ready;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IDEXWrite;
    logic       EXMEMWrite;
    logic       IDEXBubble;
    logic       IFIDFlush;
    logic       IDEXFlush;
    logic       mem_timeout;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble, IFIDFlush, IDEXFlush}
    logic [6:0] outs;
    localparam logic [6:0] RunAll  = 7'b1111_000;
    localparam logic [6:0] LoadUse = 7'b0011_100;
    localparam logic [6:0] Flush   = 7'b1111_011;
    localparam logic [6:0] Freeze  = 7'b0000_000;

    assign outs = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble, IFIDFlush, IDEXFlush};

    hazard_ctrl #(
        .TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_RsAddr     (id_RsAddr),
        .id_RtAddr     (id_RtAddr),
        .id_ex_MemRead (id_ex_MemRead),
        .id_ex_RtAddr  (id_ex_RtAddr),
        .ex_BranchTaken(ex_BranchTaken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IDEXWrite     (IDEXWrite),
        .EXMEMWrite    (EXMEMWrite),
        .IDEXBubble    (IDEXBubble),
        .IFIDFlush     (IFIDFlush),
        .IDEXFlush     (IDEXFlush),
        .mem_timeout   (mem_timeout)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic req,
                         input logic rdy);
        @(negedge clk);
        id_ex_MemRead  = mr;
        id_ex_RtAddr   = ex_rt;
        id_RsAddr      = rs;
        id_RtAddr      = rt;
        ex_BranchTaken = br;
        mem_req        = req;
        mem_ready      = rdy;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        id_RsAddr      = '0;
        id_RtAddr      = '0;
        id_ex_MemRead  = 1'b0;
        id_ex_RtAddr   = '0;
        ex_BranchTaken = 1'b0;
        mem_req        = 1'b0;
        mem_ready      = 1'b0;
        #3;
        check_eq("reset_outs", 32'(outs), 32'(Freeze));
        check_eq("reset_timeout", 32'(mem_timeout), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check_eq("reset_stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("idle_run", 32'(outs), 32'(RunAll));

        // Load-use on Rs, then NOP in EX the next cycle.
        drive(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0);
        check_eq("loaduse_rs", 32'(outs), 32'(LoadUse));
        drive(1'b0, 5'd0, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0);
        check_eq("loaduse_release", 32'(outs), 32'(RunAll));
        drive(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0);
        check_eq("loaduse_rt", 32'(outs), 32'(LoadUse));
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("loaduse_r0", 32'(outs), 32'(RunAll));
        drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0);
        check_eq("load_no_dep", 32'(outs), 32'(RunAll));
        drive(1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0);
        check_eq("no_memread", 32'(outs), 32'(RunAll));

        // Branch beats load-use; branch alone.
        drive(1'b1, 5'd8, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);
        check_eq("branch_over_loaduse", 32'(outs), 32'(Flush));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        check_eq("branch_only", 32'(outs), 32'(Flush));

        // Zero-wait access stays in RUN: the next idle cycle must not be frozen.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check_eq("zero_wait", 32'(outs), 32'(RunAll));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("zero_wait_after", 32'(outs), 32'(RunAll));

        // Three-cycle memory wait; first cycle also carries branch + load-use.
        drive(1'b1, 5'd8, 5'd8, 5'd1, 1'b1, 1'b1, 1'b0);
        check_eq("memstall_priority", 32'(outs), 32'(Freeze));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check_eq("memwait_1", 32'(outs), 32'(Freeze));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check_eq("memwait_2", 32'(outs), 32'(Freeze));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check_eq("memwait_ready", 32'(outs), 32'(RunAll));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("memwait_back_run", 32'(outs), 32'(RunAll));
        check_eq("memwait_no_timeout", 32'(mem_timeout), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        // Two load-use cycles earlier plus three frozen cycles.
        check_eq("stall_cnt_after_wait", stall_cnt, 32'd5);
`endif

        // Timeout: cycle 0 is the RUN stall, cycles 1..9 are MEM_WAIT; the flag rises
        // at the edge closing the 4th MEM_WAIT cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            check_eq($sformatf("timeout_outs_%0d", i), 32'(outs), 32'(Freeze));
            check_eq($sformatf("timeout_flag_%0d", i), 32'(mem_timeout),
                     (i >= 5) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check_eq("timeout_ready", 32'(outs), 32'(RunAll));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("timeout_run", 32'(outs), 32'(RunAll));
        check_eq("timeout_sticky", 32'(mem_timeout), 32'd1);
`ifdef HAZARD_STALL_CNT_EN
        check_eq("stall_cnt_after_timeout", stall_cnt, 32'd15);
`endif

        // Async reset in the middle of a MEM_WAIT cycle, released before the next edge.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check_eq("pre_reset_wait", 32'(outs), 32'(Freeze));
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outs", 32'(outs), 32'(Freeze));
        check_eq("async_reset_timeout", 32'(mem_timeout), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check_eq("async_reset_stall_cnt", stall_cnt, 32'd0);
`endif
        mem_req = 1'b0;
        rst_n   = 1'b1;
        #1;
        check_eq("post_reset_run", 32'(outs), 32'(RunAll));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("post_reset_run_2", 32'(outs), 32'(RunAll));
        check_eq("post_reset_timeout", 32'(mem_timeout), 32'd0);
        drive(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0);
        check_eq("post_reset_loaduse", 32'(outs), 32'(LoadUse));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
